// File: rtl/am9513_pkg.sv
// Shared opcode/status enumerations and widths for the AM9513 operand stack bank.
package am9513_pkg;

  localparam int unsigned OP_W         = 3;
  localparam int unsigned ST_W         = 2;
  localparam int unsigned CH_W         = 4;
  localparam int unsigned STAT_DEPTH_W = 9;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_PEEK  = 3'd2,
    OP_DUP   = 3'd3,
    OP_SWAP  = 3'd4,
    OP_CLEAR = 3'd5,
    OP_STAT  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_OK        = 2'd0,
    ST_OVERFLOW  = 2'd1,
    ST_UNDERFLOW = 2'd2,
    ST_ILLEGAL   = 2'd3
  } status_e;

endpackage

// File: rtl/am9513_stack_lane.sv
// One operand stack: storage, depth pointer, sticky flags and per-op result.
module am9513_stack_lane
  import am9513_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata_c,
  output status_e           o_status_c,
  output logic              o_empty,
  output logic              o_full
);

  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SLOTS = 1 << AW;

  logic [DATA_W-1:0] r_mem [SLOTS];
  logic [DW-1:0]     r_depth;
  logic              r_ovf;
  logic              r_unf;

  logic [AW-1:0]     w_new_idx;
  logic [AW-1:0]     w_top_idx;
  logic [AW-1:0]     w_nxt_idx;
  logic [DATA_W-1:0] w_top;
  logic [DATA_W-1:0] w_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_dup;
  logic              w_swap;
  logic              w_clear;

  assign w_new_idx = AW'(r_depth);
  assign w_top_idx = AW'(r_depth - DW'(1));
  assign w_nxt_idx = AW'(r_depth - DW'(2));
  assign w_top     = r_mem[w_top_idx];
  assign w_nxt     = r_mem[w_nxt_idx];
  assign o_empty   = (r_depth == '0);
  assign o_full    = (r_depth == DW'(DEPTH));

  // Decode the op against the current depth: legality, result data and state actions.
  always_comb begin
    o_status_c = ST_OK;
    o_rdata_c  = '0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_dup      = 1'b0;
    w_swap     = 1'b0;
    w_clear    = 1'b0;
    case (i_op)
      OP_PUSH: begin
        if (r_depth < DW'(DEPTH)) w_push = 1'b1;
        else                      o_status_c = ST_OVERFLOW;
      end
      OP_POP: begin
        if (r_depth != '0) begin
          w_pop     = 1'b1;
          o_rdata_c = w_top;
        end else begin
          o_status_c = ST_UNDERFLOW;
        end
      end
      OP_PEEK: begin
        if (r_depth != '0) o_rdata_c  = w_top;
        else               o_status_c = ST_UNDERFLOW;
      end
      OP_DUP: begin
        if (r_depth == '0) begin
          o_status_c = ST_UNDERFLOW;
        end else if (r_depth == DW'(DEPTH)) begin
          o_status_c = ST_OVERFLOW;
        end else begin
          w_dup     = 1'b1;
          o_rdata_c = w_top;
        end
      end
      OP_SWAP: begin
        if (r_depth < DW'(2)) begin
          o_status_c = ST_UNDERFLOW;
        end else begin
          w_swap    = 1'b1;
          o_rdata_c = w_nxt;
        end
      end
      OP_CLEAR: w_clear = 1'b1;
      OP_STAT: begin
        o_rdata_c[STAT_DEPTH_W-1:0] = STAT_DEPTH_W'(r_depth);
        o_rdata_c[16]               = r_ovf;
        o_rdata_c[17]               = r_unf;
      end
      default: o_status_c = ST_ILLEGAL;
    endcase
  end

  // Depth pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_en) begin
      if (w_push || w_dup) r_depth <= r_depth + DW'(1);
      if (w_pop)           r_depth <= r_depth - DW'(1);
      if (w_clear) begin
        r_depth <= '0;
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
      end
      if (o_status_c == ST_OVERFLOW)  r_ovf <= 1'b1;
      if (o_status_c == ST_UNDERFLOW) r_unf <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_en && !rst) begin
      if (w_push) r_mem[w_new_idx] <= i_wdata;
      if (w_dup)  r_mem[w_new_idx] <= w_top;
      if (w_swap) begin
        r_mem[w_top_idx] <= w_nxt;
        r_mem[w_nxt_idx] <= w_top;
      end
    end
  end

endmodule

// File: rtl/am9513_stack_bank.sv
// Bank of NUM_CH operand stacks shared by a host port (A) and a priority engine port (B).
module am9513_stack_bank
  import am9513_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [2:0]        a_req_op,
  input  logic [3:0]        a_req_ch,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_rdata,
  output logic [1:0]        a_rsp_status,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [2:0]        b_req_op,
  input  logic [3:0]        b_req_ch,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [1:0]        b_rsp_status,
  output logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_full
);

  logic              r_a_rsp_valid;
  logic [DATA_W-1:0] r_a_rsp_rdata;
  status_e           r_a_rsp_status;
  logic              r_b_rsp_valid;
  logic [DATA_W-1:0] r_b_rsp_rdata;
  status_e           r_b_rsp_status;

  logic              w_a_fire;
  logic              w_b_fire;
  logic              w_exec;
  logic              w_illegal;
  op_e               w_op;
  logic [CH_W-1:0]   w_ch;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rsp_rdata;
  status_e           w_rsp_status;
  logic [DATA_W-1:0] w_lane_rdata  [NUM_CH];
  status_e           w_lane_status [NUM_CH];

  // B has priority; A is also held off while B presents a request.
  assign b_req_ready = !rst && !r_b_rsp_valid;
  assign a_req_ready = !rst && !r_a_rsp_valid && !b_req_valid;
  assign w_b_fire    = b_req_valid && b_req_ready;
  assign w_a_fire    = a_req_valid && a_req_ready;

  assign w_op      = w_b_fire ? op_e'(b_req_op) : op_e'(a_req_op);
  assign w_ch      = w_b_fire ? b_req_ch : a_req_ch;
  assign w_wdata   = w_b_fire ? b_req_wdata : a_req_wdata;
  assign w_illegal = (32'(w_ch) >= NUM_CH) || (w_op == OP_RSVD);
  assign w_exec    = (w_a_fire || w_b_fire) && !w_illegal;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    am9513_stack_lane #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_exec && (w_ch == CH_W'(g))),
      .i_op       (w_op),
      .i_wdata    (w_wdata),
      .o_rdata_c  (w_lane_rdata[g]),
      .o_status_c (w_lane_status[g]),
      .o_empty    (ch_empty[g]),
      .o_full     (ch_full[g])
    );
  end

  // Select the addressed lane's result, or report an illegal request.
  always_comb begin
    w_rsp_rdata  = '0;
    w_rsp_status = ST_ILLEGAL;
    if (!w_illegal) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_ch == CH_W'(i)) begin
          w_rsp_rdata  = w_lane_rdata[i];
          w_rsp_status = w_lane_status[i];
        end
      end
    end
  end

  // Per-port response registers; a fired op's result is held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rsp_valid  <= 1'b0;
      r_a_rsp_rdata  <= '0;
      r_a_rsp_status <= ST_OK;
      r_b_rsp_valid  <= 1'b0;
      r_b_rsp_rdata  <= '0;
      r_b_rsp_status <= ST_OK;
    end else begin
      if (w_a_fire) begin
        r_a_rsp_valid  <= 1'b1;
        r_a_rsp_rdata  <= w_rsp_rdata;
        r_a_rsp_status <= w_rsp_status;
      end else if (a_rsp_ready) begin
        r_a_rsp_valid  <= 1'b0;
      end
      if (w_b_fire) begin
        r_b_rsp_valid  <= 1'b1;
        r_b_rsp_rdata  <= w_rsp_rdata;
        r_b_rsp_status <= w_rsp_status;
      end else if (b_rsp_ready) begin
        r_b_rsp_valid  <= 1'b0;
      end
    end
  end

  assign a_rsp_valid  = r_a_rsp_valid;
  assign a_rsp_rdata  = r_a_rsp_rdata;
  assign a_rsp_status = r_a_rsp_status;
  assign b_rsp_valid  = r_b_rsp_valid;
  assign b_rsp_rdata  = r_b_rsp_rdata;
  assign b_rsp_status = r_b_rsp_status;

endmodule

// File: doc/am9513_stack_bank.md
AM9513_STACK_BANK -- requirements
Module: am9513_stack_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent operand stacks; legal range 1..16.
REQ-002 Parameter DEPTH, default 16: entries per stack; legal range 2..256.
REQ-003 Parameter DATA_W, default 64: entry width in bits.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_req_valid/a_req_ready  in/out  1/1  host port request handshake; lower priority.
REQ-007 a_req_op  in  3  opcode: 0 PUSH, 1 POP, 2 PEEK, 3 DUP, 4 SWAP, 5 CLEAR, 6 STAT, 7 reserved.
REQ-008 a_req_ch  in  4  target channel; a_req_wdata  in  DATA_W  PUSH operand.
REQ-009 a_rsp_valid/a_rsp_ready  out/in  1/1  host response handshake; a_rsp_rdata  out  DATA_W; a_rsp_status  out  2.
REQ-010 b_* ports SHALL mirror REQ-006..009 exactly: engine port, higher priority.
REQ-011 ch_empty/ch_full  out  NUM_CH each  per-channel combinational level flags.

Function
REQ-012 A request fires when req_valid and req_ready are both high; each port has at most one outstanding response.
REQ-013 b_req_ready SHALL be high iff b_rsp_valid is low.
REQ-014 a_req_ready SHALL be high iff a_rsp_valid is low and b_req_valid is low (B wins any same-cycle contention).
REQ-015 A fired op SHALL execute in the firing cycle; rsp_valid SHALL rise on the next cycle and hold, with stable data, until rsp_ready.
REQ-016 Status codes: 0 OK, 1 OVERFLOW, 2 UNDERFLOW, 3 ILLEGAL (ch >= NUM_CH or op 7); a non-OK op SHALL leave stack state unchanged except the sticky flags.
REQ-017 PUSH: requires depth < DEPTH; writes wdata at top; rdata = 0.
REQ-018 POP: requires depth >= 1; rdata = old top; depth decrements.
REQ-019 PEEK: requires depth >= 1; rdata = top; no state change.
REQ-020 DUP: requires 1 <= depth < DEPTH; copies top; rdata = top.
REQ-021 SWAP: requires depth >= 2; exchanges top and next entries; rdata = new top.
REQ-022 CLEAR: sets depth to 0 and clears the channel's sticky flags; always OK; rdata = 0.
REQ-023 STAT: rdata[8:0] = depth, rdata[16] = sticky overflow, rdata[17] = sticky underflow, all other bits 0; always OK.
REQ-024 OVERFLOW SHALL set the channel's sticky overflow flag; UNDERFLOW SHALL set its sticky underflow flag; ILLEGAL sets no flag.
REQ-025 Depth counters SHALL be $clog2(DEPTH+1) bits and never wrap; full means depth == DEPTH.
REQ-026 On failed ops, rdata SHALL be 0.
REQ-027 Only one op executes per cycle, so cross-port hazards cannot occur; an A op on a channel SHALL observe every earlier-fired B op on that channel.

Reset
REQ-028 When rst is high, all depths, sticky flags, rsp_valid, rdata and status registers SHALL clear to 0 on the next edge; ch_empty then reads all-ones and ch_full all-zeros.
REQ-029 A response pending at reset SHALL be discarded; storage contents need no reset.
REQ-030 req_ready SHALL be low while rst is high.

Structure
REQ-031 Opcode and status enumerations SHALL live in am9513_pkg.
REQ-032 Per-channel storage and pointer SHALL be one sub-module, am9513_stack_lane, instantiated NUM_CH times; arbitration and responses SHALL live in the top module.

Verification
REQ-033 ch0: PUSH 0x11, PUSH 0x22, SWAP, POP -> SWAP returns rdata 0x11; POP returns 0x11 status 0; STAT returns depth 1.
REQ-034 DEPTH=4: five PUSHes to ch1 -> fifth returns status 1; STAT returns rdata 0x1_0004; CLEAR then STAT returns 0.
REQ-035 Empty ch2: POP and SWAP -> status 2; sticky underflow set; depth stays 0.
REQ-036 Same-cycle A PUSH 0xAA and B PUSH 0xBB on ch3 -> B fires first, A fires the next cycle; POP returns 0xAA, then 0xBB.
REQ-037 Hold a_rsp_ready low for 5 cycles -> a_rsp_valid, rdata and status stay stable, a_req_ready stays low, and the B port proceeds unaffected.
REQ-038 Assert rst mid-sequence with a response pending -> rsp_valid is 0 and all channels are empty the next cycle; ch=NUM_CH or op 7 -> status 3.
